// File: rtl/mem_pkg.sv
// Shared encodings and types for the data memory responder and its lane logic.
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } mem_state_t;

    typedef struct packed {
        logic [31:0] read_data;
        logic        error;
    } mem_resp_t;

endpackage

// File: rtl/mem_lane_extend.sv
// Selects the byte/halfword lane of a memory word and sign- or zero-extends it to 32 bits.
module mem_lane_extend
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_offset,
    input  logic [1:0]  length,
    input  logic        is_signed,
    output logic [31:0] data
);

    logic signed [7:0]  byte_lane;
    logic signed [15:0] half_lane;

    always_comb begin
        byte_lane = word[8*byte_offset +: 8];
        half_lane = byte_offset[1] ? word[31:16] : word[15:0];
        data      = word;
        case (length)
            MEM_BYTE: data = is_signed ? {{24{byte_lane[7]}}, byte_lane} : {24'b0, byte_lane};
            MEM_HALF: data = is_signed ? {{16{half_lane[15]}}, half_lane} : {16'b0, half_lane};
            default:  data = word;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: one outstanding load/store, programmable latency.
// Define MEM_ALIGN_CHECK_EN to report misaligned halfword/word requests through resp_error.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,
    input  logic [1:0]  req_length,
    input  logic        req_signed,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_read_data,
    output logic        resp_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    mem_state_t    state;
    logic [CW-1:0] cnt;
    logic          vld_p1;
    mem_resp_t     resp_q;

    logic          write_p0;
    logic          signed_p0;
    logic [AW+1:0] addr_p0;
    logic [31:0]   wdata_p0;
    logic [1:0]    len_p0;

    logic [31:0]   rd_word_p1;
    logic [31:0]   ext_data;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data;
    logic          misaligned;
    logic          accept;
    logic          finish;
    logic [AW-1:0] idx;
    logic          unused_addr_hi;

    logic [31:0]   mem [DEPTH];

    assign accept         = (state == IDLE) && req_valid && req_ready;
    assign finish         = (state == ACCESS) && vld_p1;
    assign idx            = addr_p0[AW+1:2];
    assign unused_addr_hi = ^req_address[31:AW+2];

    assign resp_read_data = resp_q.read_data;
    assign resp_error     = resp_q.error;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ((len_p0 == MEM_HALF) && addr_p0[0]) ||
                        (len_p0[1] && (addr_p0[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Stage p0: request fields captured at accept
    always_ff @(posedge clock) begin
        if (accept) begin
            write_p0  <= req_write;
            signed_p0 <= req_signed;
            addr_p0   <= req_address[AW+1:0];
            wdata_p0  <= req_write_data;
            len_p0    <= req_length;
        end
    end

    // Store lanes; low address bits below the access size simply fall out of the lane choice
    always_comb begin
        lane_en   = 4'b0000;
        lane_data = wdata_p0;
        case (len_p0)
            MEM_BYTE: begin
                lane_en   = 4'b0001 << addr_p0[1:0];
                lane_data = {4{wdata_p0[7:0]}};
            end
            MEM_HALF: begin
                lane_en   = addr_p0[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata_p0[15:0]}};
            end
            default: lane_en = 4'b1111;
        endcase
        if (misaligned || !write_p0) lane_en = 4'b0000;
    end

    // Stage p1: synchronous array read once the latency count expires; store commits on finish
    always_ff @(posedge clock) begin
        if ((state == ACCESS) && (cnt == '0) && !vld_p1) rd_word_p1 <= mem[idx];
        if (finish && reset) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) mem[idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

    mem_lane_extend u_lane_extend (
        .word        (rd_word_p1),
        .byte_offset (addr_p0[1:0]),
        .length      (len_p0),
        .is_signed   (signed_p0),
        .data        (ext_data)
    );

    // Stage p2: registered response and handshake control
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            vld_p1     <= 1'b0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        state     <= ACCESS;
                        cnt       <= CNT_LOAD;
                        req_ready <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (vld_p1) begin
                        vld_p1            <= 1'b0;
                        state             <= RESP;
                        resp_valid        <= 1'b1;
                        resp_q.read_data  <= (write_p0 || misaligned) ? 32'b0 : ext_data;
                        resp_q.error      <= misaligned;
                    end else if (cnt == '0) begin
                        vld_p1 <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a byte-addressed reference model.
module tb_data_mem_responder;

    localparam int LAT = 2;
    localparam int DEP = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_address = 32'b0;
    logic [31:0] req_write_data = 32'b0;
    logic [1:0]  req_length = 2'b0;
    logic        req_signed = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_read_data;
    logic        resp_error;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_lat = 0;
    bit chk_en = 1'b0;
    bit rr_rand = 1'b0;

    // reference model state
    logic [7:0]  mb [4*DEP];
    logic        m_ready = 1'b0;
    logic        m_rv = 1'b0;
    logic [31:0] m_data = 32'b0;
    logic        m_err = 1'b0;
    int          m_phase = 0;
    int          m_wait = 0;
    logic        m_w = 1'b0;
    logic        m_s = 1'b0;
    logic [31:0] m_a = 32'b0;
    logic [31:0] m_d = 32'b0;
    logic [1:0]  m_len = 2'b0;

    data_mem_responder #(.DEPTH(DEP), .LATENCY(LAT)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_address    (req_address),
        .req_write_data (req_write_data),
        .req_length     (req_length),
        .req_signed     (req_signed),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_read_data (resp_read_data),
        .resp_error     (resp_error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Completes the captured request on the byte-level model.
    task automatic model_complete;
        int          n;
        logic [31:0] base;
        logic [31:0] v;
        logic        mis;
        n    = (m_len == 2'b00) ? 1 : (m_len == 2'b01) ? 2 : 4;
        mis  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis  = (m_a % n) != 0;
`endif
        base = (m_a - (m_a % n)) % (4 * DEP);
        m_err = mis;
        if (mis) begin
            m_data = 32'b0;
        end else if (m_w) begin
            for (int i = 0; i < n; i++) mb[base + i] = m_d[8*i +: 8];
            m_data = 32'b0;
        end else begin
            v = 32'b0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mb[base + i];
            if (m_s && n < 4 && v[8*n-1]) begin
                for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
            end
            m_data = v;
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] len, input logic sg);
        int n;
        req_write = w;
        req_address = a;
        req_write_data = d;
        req_length = len;
        req_signed = sg;
        req_valid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) fail_timeout("request_accept");
        acc_cyc = cyc + 1;
        tick();
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_address = $urandom;
        req_write_data = $urandom;
        req_length = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic get(output logic [31:0] d, output logic e);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        d = 32'b0;
        e = 1'b0;
        forever begin
            if (rr_rand) resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            if (resp_valid && !seen) begin
                seen = 1'b1;
                last_lat = cyc - acc_cyc;
            end
            if (resp_valid && resp_ready) begin
                d = resp_read_data;
                e = resp_error;
                break;
            end
            n++;
            if (n > 200) begin
                fail_timeout("response_handshake");
                break;
            end
            @(posedge clock);
            #1;
        end
        tick();
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] len, input logic sg,
                        output logic [31:0] d, output logic e);
        send(w, a, wd, len, sg);
        get(d, e);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;

        tick();
        chk_en = 1'b1;
        fork
            forever begin
                @(negedge clock);
                chk("req_ready", {31'b0, req_ready}, {31'b0, m_ready});
                chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_rv});
                chk("resp_read_data", resp_read_data, m_data);
                chk("resp_error", {31'b0, resp_error}, {31'b0, m_err});
                if (!reset) begin
                    m_ready = 1'b0;
                    m_rv    = 1'b0;
                    m_data  = 32'b0;
                    m_err   = 1'b0;
                    m_phase = 0;
                end else begin
                    case (m_phase)
                        0: begin
                            if (m_ready && req_valid) begin
                                m_w = req_write;
                                m_a = req_address;
                                m_d = req_write_data;
                                m_len = req_length;
                                m_s = req_signed;
                                m_ready = 1'b0;
                                m_wait = LAT + 1;
                                m_phase = 1;
                            end else begin
                                m_ready = 1'b1;
                            end
                        end
                        1: begin
                            m_wait--;
                            if (m_wait == 0) begin
                                model_complete();
                                m_rv = 1'b1;
                                m_phase = 2;
                            end
                        end
                        default: begin
                            if (resp_ready) begin
                                m_rv = 1'b0;
                                m_ready = 1'b1;
                                m_phase = 0;
                            end
                        end
                    endcase
                end
            end
        join_none

        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_read_data", resp_read_data, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("ready_after_reset", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 20; i++) xfer(1'b1, 32'(i * 4), $urandom, 2'b10, 1'b0, d, e);

        xfer(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, d, e);
        chk("store_ack_data", d, 32'h0);
        xfer(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, d, e);
        chk("load_word_10", d, 32'hDEADBEEF);
        chk("load_latency", 32'(last_lat), 32'(LAT + 1));

        xfer(1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, d, e);
        xfer(1'b1, 32'h21, 32'hABCDEF80, 2'b00, 1'b0, d, e);
        xfer(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, d, e);
        chk("byte_merge_word", d, 32'h11228044);
        xfer(1'b0, 32'h21, 32'h0, 2'b00, 1'b1, d, e);
        chk("load_sbyte_21", d, 32'hFFFFFF80);
        xfer(1'b0, 32'h21, 32'h0, 2'b00, 1'b0, d, e);
        chk("load_ubyte_21", d, 32'h00000080);

        xfer(1'b1, 32'h20, 32'h80017FFF, 2'b10, 1'b0, d, e);
        xfer(1'b0, 32'h22, 32'h0, 2'b01, 1'b1, d, e);
        chk("load_shalf_22", d, 32'hFFFF8001);
        xfer(1'b0, 32'h22, 32'h0, 2'b01, 1'b0, d, e);
        chk("load_uhalf_22", d, 32'h00008001);

        resp_ready = 1'b0;
        send(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        repeat (LAT + 3) tick();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_address = 32'h10;
        req_write_data = 32'h0;
        req_length = 2'b10;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        chk("stall_resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
        chk("stall_data", resp_read_data, 32'hDEADBEEF);
        resp_ready = 1'b1;
        get(d, e);
        xfer(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, d, e);
        chk("ignored_pulse_mem", d, 32'hDEADBEEF);

        xfer(1'b1, 32'h40, 32'hCAFEF00D, 2'b10, 1'b0, d, e);
        send(1'b1, 32'h40, 32'h12345678, 2'b10, 1'b0);
        reset = 1'b0;
        tick();
        chk("access_rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("access_rst_ready", {31'b0, req_ready}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        xfer(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, d, e);
        chk("store_dropped_by_reset", d, 32'hCAFEF00D);

        xfer(1'b1, 32'h42, 32'hA5A5A5A5, 2'b10, 1'b0, d, e);
`ifdef MEM_ALIGN_CHECK_EN
        chk("misaligned_error", {31'b0, e}, 32'd1);
        xfer(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, d, e);
        chk("misaligned_no_write", d, 32'hCAFEF00D);
`else
        chk("misaligned_error", {31'b0, e}, 32'd0);
        xfer(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, d, e);
        chk("unaligned_word_write", d, 32'hA5A5A5A5);
`endif

        rr_rand = 1'b1;
        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 79));
            xfer(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), d, e);
            repeat ($urandom_range(0, 2)) tick();
        end
        rr_rand = 1'b0;
        resp_ready = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
